// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the pipelined load/store stage: access sizes and the
// metadata carried for each in-flight bus request.
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_t;

  typedef struct packed {
    logic [4:0] reg_addr;
    logic       reg_write;
    size_t      size;
    logic       unsigned_load;
    logic [1:0] offset;
  } lsq_entry_t;

  // The reserved encoding behaves as a word access.
  function automatic size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SIZE_BYTE;
      2'd1:    return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsq_fifo.sv
// In-order FIFO of in-flight request metadata; head is visible combinationally
// so a response can be formatted on the same edge it pops the entry.
module lsq_fifo
  import ecap5_dproc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  lsq_entry_t               push_data_i,
  input  logic                     pop_i,
  output lsq_entry_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  lsq_entry_t        mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/loadstore_pipelined.sv
// Memory stage issuing Wishbone B4 pipelined requests back to back, with
// in-order retirement of loads, stores, pass-through and faulting ops.
module loadstore_pipelined
  import ecap5_dproc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  input_ready_o,
  input  logic                  input_valid_i,
  input  logic [31:0]           alu_result_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  input  logic [31:0]           write_data_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_load_i,
  input  logic                  reg_write_i,
  input  logic [4:0]            reg_addr_i,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic                  wb_cyc_o,
  input  logic                  wb_stall_i,
  output logic                  output_valid_o,
  output logic                  reg_write_o,
  output logic [4:0]            reg_addr_o,
  output logic [31:0]           reg_data_o,
  output logic                  misaligned_o,
  output logic                  bus_error_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [ADDR_WIDTH-1:0] wb_adr_q, wb_adr_d;
  logic [31:0]           wb_dat_q, wb_dat_d;
  logic                  wb_we_q, wb_we_d;
  logic [3:0]            wb_sel_q, wb_sel_d;
  logic                  wb_stb_q, wb_stb_d;
  logic                  out_valid_q, out_valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [4:0]            reg_addr_q, reg_addr_d;
  logic [31:0]           reg_data_q, reg_data_d;
  logic                  misaligned_q, misaligned_d;
  logic                  bus_error_q, bus_error_d;

  lsq_entry_t    push_entry, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [1:0]    offset;
  size_t         size_e;
  logic          misaligned, mem_op, idle, accept, issue, term;
  logic [3:0]    sel_base;
  logic [31:0]   rd_shifted, load_data;

  assign offset     = alu_result_i[1:0];
  assign size_e     = decode_size(size_i);
  assign misaligned = ((size_e == SIZE_HALF) && offset[0]) ||
                      ((size_e == SIZE_WORD) && (offset != 2'd0));
  assign mem_op     = enable_i && !misaligned;
  assign idle       = fifo_empty && !wb_stb_q;

  // Anything that retires without a bus response must wait for the bus to
  // drain, otherwise it would overtake older loads.
  assign input_ready_o = mem_op ? (!fifo_full && !(wb_stb_q && wb_stall_i)) : idle;
  assign accept        = input_valid_i && input_ready_o;
  assign issue         = accept && mem_op;
  assign term          = (wb_ack_i || wb_err_i) && !fifo_empty;

  always_comb begin
    push_entry               = '0;
    push_entry.reg_addr      = reg_addr_i;
    push_entry.reg_write     = reg_write_i && !write_i;
    push_entry.size          = size_e;
    push_entry.unsigned_load = unsigned_load_i;
    push_entry.offset        = offset;
  end

  lsq_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (issue),
    .push_data_i (push_entry),
    .pop_i       (term),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    case (size_e)
      SIZE_BYTE: sel_base = 4'b0001;
      SIZE_HALF: sel_base = 4'b0011;
      default:   sel_base = 4'b1111;
    endcase
  end

  assign rd_shifted = wb_dat_i >> {head.offset, 3'b000};

  always_comb begin
    case (head.size)
      SIZE_BYTE: load_data = {{24{!head.unsigned_load && rd_shifted[7]}}, rd_shifted[7:0]};
      SIZE_HALF: load_data = {{16{!head.unsigned_load && rd_shifted[15]}}, rd_shifted[15:0]};
      default:   load_data = rd_shifted;
    endcase
  end

  always_comb begin
    wb_adr_d     = wb_adr_q;
    wb_dat_d     = wb_dat_q;
    wb_we_d      = wb_we_q;
    wb_sel_d     = wb_sel_q;
    wb_stb_d     = wb_stb_q;
    out_valid_d  = 1'b0;
    reg_write_d  = 1'b0;
    reg_addr_d   = 5'd0;
    reg_data_d   = 32'd0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;

    if (wb_stb_q && !wb_stall_i) wb_stb_d = 1'b0;
    // A new request may replace the one the slave accepts on this edge.
    if (issue) begin
      wb_adr_d = ADDR_WIDTH'({alu_result_i[31:2], 2'b00});
      wb_sel_d = sel_base << offset;
      wb_dat_d = write_data_i << {offset, 3'b000};
      wb_we_d  = write_i;
      wb_stb_d = 1'b1;
    end

    if (term) begin
      out_valid_d = 1'b1;
      reg_addr_d  = head.reg_addr;
      if (wb_err_i) begin
        bus_error_d = 1'b1;
      end else begin
        reg_write_d = head.reg_write;
        reg_data_d  = load_data;
      end
    end else if (accept && !mem_op) begin
      out_valid_d = 1'b1;
      reg_addr_d  = reg_addr_i;
      reg_data_d  = alu_result_i;
      if (enable_i) misaligned_d = 1'b1;
      else          reg_write_d  = reg_write_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_adr_q     <= '0;
      wb_dat_q     <= '0;
      wb_we_q      <= 1'b0;
      wb_sel_q     <= '0;
      wb_stb_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      wb_adr_q     <= wb_adr_d;
      wb_dat_q     <= wb_dat_d;
      wb_we_q      <= wb_we_d;
      wb_sel_q     <= wb_sel_d;
      wb_stb_q     <= wb_stb_d;
      out_valid_q  <= out_valid_d;
      reg_write_q  <= reg_write_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign wb_adr_o       = wb_adr_q;
  assign wb_dat_o       = wb_dat_q;
  assign wb_we_o        = wb_we_q;
  assign wb_sel_o       = wb_sel_q;
  assign wb_stb_o       = wb_stb_q;
  assign wb_cyc_o       = wb_stb_q || (fifo_count != '0);
  assign output_valid_o = out_valid_q;
  assign reg_write_o    = reg_write_q;
  assign reg_addr_o     = reg_addr_q;
  assign reg_data_o     = reg_data_q;
  assign misaligned_o   = misaligned_q;
  assign bus_error_o    = bus_error_q;

endmodule

// File: tb/tb_loadstore_pipelined.sv
// Scoreboard bench: expected bus requests and retire results are queued when
// an op is accepted, then compared when the slave model or the write-back port sees them.
module tb_loadstore_pipelined;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        input_ready_o, input_valid_i = 1'b0;
  logic [31:0] alu_result_i = '0, write_data_i = '0;
  logic        enable_i = 1'b0, write_i = 1'b0, unsigned_load_i = 1'b0, reg_write_i = 1'b0;
  logic [1:0]  size_i = '0;
  logic [4:0]  reg_addr_i = '0;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = '0;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;
  logic        output_valid_o, reg_write_o, misaligned_o, bus_error_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;

  loadstore_pipelined #(.MAX_OUTSTANDING(4), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .input_ready_o(input_ready_o), .input_valid_i(input_valid_i),
    .alu_result_i(alu_result_i), .enable_i(enable_i), .write_i(write_i),
    .write_data_i(write_data_i), .size_i(size_i), .unsigned_load_i(unsigned_load_i),
    .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i),
    .output_valid_o(output_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
    .reg_data_o(reg_data_o), .misaligned_o(misaligned_o), .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic mis; logic berr; logic rw; logic [4:0] rd; logic [31:0] data; logic chk_data; } res_t;
  typedef struct { logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; logic we; } req_t;
  typedef struct { logic [31:0] adr; int due; } pend_t;

  res_t  exp_res[$];
  req_t  exp_req[$];
  pend_t pend[$];

  int checks = 0, errors = 0;
  int cyc = 0, lat = 1, stall_cnt = 0, acc_count = 0, out_count = 0;
  bit err_next = 1'b0, stray = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdata(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h80FF_FF00;
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    s = w >> (8 * off);
    case (sz)
      2'd0:    return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'd1:    return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Wishbone slave model: fixed latency, optional stall burst, optional error.
  always @(negedge clk) begin
    req_t q;
    if (!rst_ni) begin
      pend.delete();
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
    end else begin
      if (stall_cnt > 0 && wb_stb_o) begin
        wb_stall_i = 1'b1;
        stall_cnt--;
      end else begin
        wb_stall_i = 1'b0;
      end
      if (wb_stb_o && wb_stall_i && exp_req.size() > 0) begin
        check("stall_adr", wb_adr_o, exp_req[0].adr);
        check("stall_sel", {28'h0, wb_sel_o}, {28'h0, exp_req[0].sel});
        check("stall_dat", wb_dat_o, exp_req[0].dat);
      end
      if (wb_stb_o && !wb_stall_i) begin
        acc_count++;
        if (exp_req.size() == 0) begin
          check("req_unexpected", 32'd1, 32'd0);
        end else begin
          q = exp_req.pop_front();
          check("req_adr", wb_adr_o, q.adr);
          check("req_sel", {28'h0, wb_sel_o}, {28'h0, q.sel});
          check("req_dat", wb_dat_o, q.dat);
          check("req_we", {31'h0, wb_we_o}, {31'h0, q.we});
          check("req_cyc", {31'h0, wb_cyc_o}, 32'd1);
        end
        pend.push_back('{adr: wb_adr_o, due: cyc + 1 + lat});
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      if (stray) begin
        wb_ack_i = 1'b1;
        stray = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        if (err_next) begin wb_err_i = 1'b1; err_next = 1'b0; end
        else wb_ack_i = 1'b1;
        wb_dat_i = rdata(pend[0].adr);
        void'(pend.pop_front());
      end
    end
  end

  // Write-back monitor.
  always @(negedge clk) begin
    res_t e;
    if (rst_ni && output_valid_o) begin
      out_count++;
      $display("retire rd=%0d rw=%0b data=%h mis=%0b berr=%0b",
               reg_addr_o, reg_write_o, reg_data_o, misaligned_o, bus_error_o);
      if (exp_res.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_res.pop_front();
        check("misaligned", {31'h0, misaligned_o}, {31'h0, e.mis});
        check("bus_error", {31'h0, bus_error_o}, {31'h0, e.berr});
        check("reg_write", {31'h0, reg_write_o}, {31'h0, e.rw});
        if (e.rw) check("reg_addr", {27'h0, reg_addr_o}, {27'h0, e.rd});
        if (e.chk_data) check("reg_data", reg_data_o, e.data);
      end
    end
  end

  task automatic do_op(input logic en, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] sz, input logic uns,
                       input logic rw, input logic [4:0] rd, input logic eerr,
                       output int waits, output int acc);
    res_t r; req_t q; logic [1:0] off; logic mis;
    @(negedge clk);
    input_valid_i = 1'b1; enable_i = en; write_i = we; alu_result_i = addr;
    write_data_i = wdata; size_i = sz; unsigned_load_i = uns; reg_write_i = rw; reg_addr_i = rd;
    waits = 0; acc = -1;
    #1;
    while (!input_ready_o) begin
      waits++;
      if (waits > 200) begin
        check("ready_timeout", 32'd0, 32'd1);
        input_valid_i = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    off = addr[1:0];
    mis = en && ((sz == 2'd1 && off[0]) || (sz >= 2'd2 && off != 2'd0));
    r.mis = 1'b0; r.berr = 1'b0; r.rw = 1'b0; r.rd = rd; r.data = '0; r.chk_data = 1'b0;
    if (!en) begin
      r.rw = rw; r.data = addr; r.chk_data = 1'b1;
    end else if (mis) begin
      r.mis = 1'b1; r.data = addr; r.chk_data = 1'b1;
    end else begin
      q.adr = {addr[31:2], 2'b00};
      q.sel = (sz == 2'd0) ? (4'b0001 << off) : (sz == 2'd1) ? (4'b0011 << off) : 4'b1111;
      q.dat = wdata << (8 * off);
      q.we  = we;
      exp_req.push_back(q);
      if (eerr) r.berr = 1'b1;
      else if (!we) begin
        r.rw = rw; r.data = load_model(rdata(q.adr), off, sz, uns); r.chk_data = 1'b1;
      end
    end
    exp_res.push_back(r);
    acc = cyc + 1;
    @(posedge clk);
    #1 input_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_res.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_res.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, a0, a1, a2, a3, n;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cyc", {31'h0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'h0, wb_stb_o}, 32'd0);
    check("rst_valid", {31'h0, output_valid_o}, 32'd0);
    check("rst_sel", {28'h0, wb_sel_o}, 32'd0);
    check("rst_data", reg_data_o, 32'd0);
    @(negedge clk); #2 rst_ni = 1'b1;

    // Signed byte load from lane 3, then half store to upper lanes.
    lat = 2;
    do_op(1, 0, 32'h0000_1003, 32'h0, 2'd0, 0, 1, 5'd5, 0, w, a0);
    drain();
    do_op(1, 1, 32'h0000_2002, 32'h0000_BEEF, 2'd1, 0, 1, 5'd6, 0, w, a0);
    drain();

    // Four back-to-back loads fill the queue; the fifth must wait for an ack.
    lat = 3;
    do_op(1, 0, 32'h0000_0100, 32'h0, 2'd2, 0, 1, 5'd1, 0, w, a0);
    do_op(1, 0, 32'h0000_0106, 32'h0, 2'd1, 0, 1, 5'd2, 0, w, a1);
    do_op(1, 0, 32'h0000_010B, 32'h0, 2'd0, 1, 1, 5'd3, 0, w, a2);
    do_op(1, 0, 32'h0000_0201, 32'h0, 2'd0, 0, 1, 5'd4, 0, w, a3);
    check("b2b_1", a1 - a0, 32'd1);
    check("b2b_2", a2 - a1, 32'd1);
    check("b2b_3", a3 - a2, 32'd1);
    do_op(1, 0, 32'h0000_0302, 32'h0, 2'd1, 1, 1, 5'd8, 0, w, a0);
    check("full_wait", {31'h0, w > 0}, 32'd1);
    drain();

    // Stall the first request for three cycles.
    lat = 1; stall_cnt = 3;
    do_op(1, 1, 32'h0000_2001, 32'h0000_00A5, 2'd0, 0, 1, 5'd10, 0, w, a0);
    do_op(1, 0, 32'h0000_2004, 32'h0, 2'd2, 0, 1, 5'd11, 0, w, a1);
    check("stall_wait", w, 32'd3);
    drain();

    // Misaligned accesses never reach the bus.
    n = acc_count;
    do_op(1, 0, 32'h0000_3001, 32'h0, 2'd2, 0, 1, 5'd9, 0, w, a0);
    do_op(1, 1, 32'h0000_3003, 32'h1234, 2'd1, 0, 0, 5'd12, 0, w, a0);
    repeat (3) @(negedge clk);
    check("mis_no_stb", acc_count, n);
    drain();
    err_next = 1'b1;
    do_op(1, 0, 32'h0000_3004, 32'h0, 2'd2, 0, 1, 5'd13, 1, w, a0);
    drain();
    do_op(0, 0, 32'h1234_5678, 32'h0, 2'd0, 0, 1, 5'd7, 0, w, a0);
    drain();

    // Reset with two loads outstanding, then a stray ack.
    lat = 20;
    do_op(1, 0, 32'h0000_4000, 32'h0, 2'd2, 0, 1, 5'd14, 0, w, a0);
    do_op(1, 0, 32'h0000_4004, 32'h0, 2'd2, 0, 1, 5'd15, 0, w, a0);
    repeat (3) @(negedge clk);
    check("mid_cyc", {31'h0, wb_cyc_o}, 32'd1);
    @(negedge clk); #2 rst_ni = 1'b0;
    #1;
    check("arst_cyc", {31'h0, wb_cyc_o}, 32'd0);
    check("arst_stb", {31'h0, wb_stb_o}, 32'd0);
    check("arst_valid", {31'h0, output_valid_o}, 32'd0);
    check("arst_adr", wb_adr_o, 32'd0);
    exp_res.delete();
    exp_req.delete();
    @(negedge clk); #2 rst_ni = 1'b1;
    n = out_count;
    stray = 1'b1;
    repeat (5) @(negedge clk);
    check("stray_ack", out_count, n);
    check("stray_cyc", {31'h0, wb_cyc_o}, 32'd0);

    lat = 1;
    do_op(1, 0, 32'h0000_5002, 32'h0, 2'd1, 0, 1, 5'd16, 0, w, a0);
    do_op(1, 1, 32'h0000_5001, 32'h0000_00C3, 2'd0, 0, 1, 5'd17, 0, w, a0);
    do_op(1, 0, 32'h0000_5008, 32'h0, 2'd2, 0, 1, 5'd18, 0, w, a0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loadstore_pipelined.md
Name: loadstore_pipelined

Overview:
Memory stage successor supporting multiple outstanding Wishbone B4 pipelined transactions, sitting between execute and write-back. Accepts one memory op per cycle, issues back-to-back requests, and tracks in-flight metadata in an in-order FIFO of depth MAX_OUTSTANDING. Adds address-based byte-lane steering, misalignment detection and bus-error reporting. Write-back results retire strictly in program order.

Parameters:
MAX_OUTSTANDING, 4, max in-flight bus requests (power of two, >=2)
ADDR_WIDTH, 32, Wishbone address width (low 2 bits used for lane steering)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
input_ready_o  out  1  stage can accept an op this cycle
input_valid_i  in  1  op valid; transfer on valid && ready
alu_result_i  in  32  effective address or pass-through result
enable_i  in  1  op is a memory access
write_i  in  1  store (1) / load (0)
write_data_i  in  32  store data, lane 0 aligned
size_i  in  2  0 byte, 1 half, 2 word (3 reserved, treated as word)
unsigned_load_i  in  1  zero-extend load result
reg_write_i  in  1  write-back enable pass-through
reg_addr_i  in  5  destination register
wb_adr_o  out  ADDR_WIDTH  word-aligned address (low 2 bits zero)
wb_dat_i  in  32  read data
wb_dat_o  out  32  lane-shifted write data
wb_we_o  out  1  write enable
wb_sel_o  out  4  lane-shifted byte select
wb_stb_o  out  1  strobe
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error, terminates one request like ack
wb_cyc_o  out  1  cycle
wb_stall_i  in  1  slave stall
output_valid_o  out  1  one result valid this cycle
reg_write_o  out  1  write-back enable
reg_addr_o  out  5  write-back register
reg_data_o  out  32  write-back data
misaligned_o  out  1  qualifies output_valid_o: misaligned access
bus_error_o  out  1  qualifies output_valid_o: wb_err_i terminated access

Behaviour:
- Reset (rst_ni low, async): all outputs 0, FIFO empty, outstanding count 0.
- offset = alu_result_i[1:0]. Misaligned: half with offset[0]=1, word with offset!=0.
- Issue register: on accepted aligned memory op, load wb_adr_o={addr[ADDR_WIDTH-1:2],2'b00}, wb_sel_o=(1/3/F)<<offset, wb_dat_o=write_data_i<<(8*offset), wb_we_o=write_i, assert wb_stb_o next cycle; push {reg_addr, reg_write&&!write_i, size, unsigned, offset} to FIFO same edge.
- stb held with all wb_* stable while wb_stall_i=1; request accepted on stb&&!stall; a new request may load on that same edge (back-to-back, no bubble).
- wb_cyc_o = wb_stb_o || FIFO non-empty; drops the cycle after last ack/err with no stb pending.
- input_ready_o (combinational from registered state): memory op ready iff FIFO count < MAX_OUTSTANDING and (!wb_stb_o || !wb_stall_i). Non-memory and misaligned ops ready only when FIFO empty and !wb_stb_o (preserves ordering).
- Non-memory op: output_valid_o next cycle, reg_data_o=alu_result_i, reg_write_o=reg_write_i.
- Misaligned op: no bus cycle; next cycle output_valid_o=1, misaligned_o=1, reg_write_o=0, reg_data_o=address.
- Ack: pop FIFO head; next cycle output_valid_o=1, reg_data_o = (wb_dat_i>>(8*offset)) truncated to size, sign- or zero-extended; stores output reg_write_o=0.
- Err: pop head; next cycle output_valid_o=1, bus_error_o=1, reg_write_o=0.
- ack/err with FIFO empty (e.g. stale after reset): ignored. ack and err same cycle: err wins.
- Push and pop same cycle when full: allowed only via ready rule (ready uses pre-pop count; no bypass).
- Latency: issue->stb 1 cycle; ack->output_valid 1 cycle. Throughput 1 op/cycle with zero-wait slave.

Decomposition:
- ecap5_dproc_pkg: size_t enum (SIZE_BYTE/HALF/WORD), lsq_entry_t packed struct for FIFO entries.
- Sub-module: lsq_fifo (parametrised synchronous FIFO, DEPTH=MAX_OUTSTANDING, push/pop/full/empty/count).

Test Plan:
- Load byte addr 0x1003, unsigned=0, wb_dat_i=0x80FF_FF00 -> wb_sel_o=0x8, wb_adr_o=0x1000, reg_data_o=0xFFFF_FF80.
- Store half 0xBEEF to addr 0x2002 -> wb_sel_o=0xC, wb_dat_o=0xBEEF_0000, wb_we_o=1, reg_write_o=0 on retire.
- 4 back-to-back loads, slave acks after 3 cycles -> 4 stb cycles consecutive, 5th op input_ready_o=0 until first ack, results in order.
- wb_stall_i=1 for 3 cycles on first request -> wb_adr_o/wb_sel_o/wb_dat_o stable, input_ready_o=0, issue resumes on release.
- Load word at 0x3001 -> no stb, output_valid_o=1, misaligned_o=1, reg_write_o=0; wb_err_i on next load -> bus_error_o=1.
- rst_ni low mid-flight with 2 outstanding -> all outputs 0 immediately; post-reset stray ack produces no output_valid_o.
